event_encoder: RTL and testbench

- Sequential 2^N-to-N encoder; the inverse of the register-file write decoder.
- Collects multi-hot event/request bits into a pending register.
- Emits one N-bit index per valid/ready handshake, lowest index first.
- Encoding is two-level, mirroring the decoder's 3/2 predecode split:
  - group select on the upper N-2 index bits (groups of 4 bits);
  - intra-group select on the lower 2 bits.
- Used to serialize register-touch events, e.g. to a debug or trace port.

---
 rtl/event_encoder.sv | 151 +++++++++++++++
 tb/tb_event_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/event_encoder.sv
// event_encoder: sequential 2^n-to-n encoder that serializes multi-hot event bits, lowest index first.
// Optional macro EVENT_ENCODER_RR_EN selects round-robin priority (search starts after the last served index).
module event_encoder #(
    parameter  int unsigned n = 5,
    localparam int unsigned W = 1 << n
) (
    input  logic         clock,
    input  logic         ctrl_reset,
    input  logic [W-1:0] req_in,
    output logic         out_valid,
    output logic [n-1:0] out_idx,
    input  logic         out_ready,
    output logic [W-1:0] pending,
    output logic         merged,
    output logic         busy
);
    localparam int unsigned IW = n;
    localparam int unsigned G  = W / 4;
    localparam int unsigned GW = (n > 2) ? n - 2 : 1;

    logic          r_valid;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_pend;
    logic          r_merged;
    logic          r_busy;

    logic [W-1:0]  w_cand;
    logic [W-1:0]  w_sel;
    logic [G-1:0]  w_grp_any;
    logic [GW-1:0] w_grp;
    logic          w_grp_hit;
    logic [3:0]    w_slice;
    logic [1:0]    w_bit;
    logic [IW-1:0] w_k;
    logic          w_slot_free;
    logic          w_load;

    logic          w_valid_n;
    logic [IW-1:0] w_idx_n;
    logic [W-1:0]  w_pend_n;
    logic          w_merged_n;

    assign w_cand      = r_pend | req_in;
    assign w_slot_free = !r_valid || out_ready;
    assign w_load      = w_slot_free && (|w_cand);

`ifdef EVENT_ENCODER_RR_EN
    logic [IW-1:0] r_ptr;
    logic [W-1:0]  w_cand_hi;

    // Bits at or above the pointer take precedence; otherwise wrap to the full vector.
    always_comb begin
        w_cand_hi = w_cand & ({W{1'b1}} << r_ptr);
        w_sel     = (|w_cand_hi) ? w_cand_hi : w_cand;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_ptr <= '0;
        end else if (w_load) begin
            r_ptr <= w_k + IW'(1);
        end
    end
`else
    always_comb begin
        w_sel = w_cand;
    end
`endif

    // Group level: one "any" flag per 4-bit slice.
    always_comb begin
        w_grp_any = '0;
        for (int unsigned g = 0; g < G; g++) begin
            w_grp_any[g] = |w_sel[4*g +: 4];
        end
    end

    // Lowest active group.
    always_comb begin
        w_grp     = '0;
        w_grp_hit = 1'b0;
        for (int unsigned g = 0; g < G; g++) begin
            if (!w_grp_hit && w_grp_any[g]) begin
                w_grp     = GW'(g);
                w_grp_hit = 1'b1;
            end
        end
    end

    // Bit level: lowest set bit inside the chosen slice.
    always_comb begin
        w_slice = '0;
        for (int unsigned g = 0; g < G; g++) begin
            if (w_grp == GW'(g)) begin
                w_slice = w_sel[4*g +: 4];
            end
        end
        w_bit = 2'd0;
        if (w_slice[0]) begin
            w_bit = 2'd0;
        end else if (w_slice[1]) begin
            w_bit = 2'd1;
        end else if (w_slice[2]) begin
            w_bit = 2'd2;
        end else if (w_slice[3]) begin
            w_bit = 2'd3;
        end
        w_k = IW'({w_grp, w_bit});
    end

    // Slot and pending next state.
    always_comb begin
        w_valid_n  = r_valid;
        w_idx_n    = r_idx;
        w_pend_n   = w_cand;
        w_merged_n = |(req_in & r_pend);
        if (w_slot_free) begin
            if (w_load) begin
                w_valid_n = 1'b1;
                w_idx_n   = w_k;
                w_pend_n  = w_cand & ~(W'(1) << w_k);
            end else begin
                w_valid_n = 1'b0;
                w_pend_n  = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_pend   <= '0;
            r_merged <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid  <= w_valid_n;
            r_idx    <= w_idx_n;
            r_pend   <= w_pend_n;
            r_merged <= w_merged_n;
            r_busy   <= w_valid_n | (|w_pend_n);
        end
    end

    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign pending   = r_pend;
    assign merged    = r_merged;
    assign busy      = r_busy;

endmodule

// File: tb/tb_event_encoder.sv
// Bench for event_encoder: directed vector table, hand-written priority sequences, randomized run vs. reference model.
module tb_event_encoder;
    localparam int unsigned N = 5;
    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         ctrl_reset = 1'b1;
    logic [W-1:0] req_in = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [N-1:0] out_idx;
    logic [W-1:0] pending;
    logic         merged;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    event_encoder #(.n(N)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .req_in     (req_in),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_ready  (out_ready),
        .pending    (pending),
        .merged     (merged),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [31:0] req;
        logic        rdy;
        logic        v;
        logic [4:0]  idx;
        logic [31:0] pend;
        logic        m;
        logic        b;
    } vec_t;

    vec_t tv[30];

    // Reference model state
    logic        m_valid;
    logic [4:0]  m_idx;
    logic [31:0] m_pend;
    logic        m_merged;
    int          m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [31:0] req, input logic rdy);
        @(negedge clock);
        ctrl_reset = rst;
        req_in     = req;
        out_ready  = rdy;
        @(posedge clock);
        #1;
    endtask

    function automatic int find_first(input logic [31:0] c, input int start);
        for (int i = 0; i < 32; i++) begin
            if (c[(start + i) % 32]) return (start + i) % 32;
        end
        return -1;
    endfunction

    // Spec-level model: candidate = pending | req, serve one index when slot free.
    task automatic model_step(input logic rst, input logic [31:0] req, input logic rdy);
        logic [31:0] c;
        int k;
        int start;
        if (rst) begin
            m_valid = 0; m_idx = 0; m_pend = 0; m_merged = 0; m_ptr = 0;
            return;
        end
        m_merged = (req & m_pend) != 0;
        c = m_pend | req;
`ifdef EVENT_ENCODER_RR_EN
        start = m_ptr;
`else
        start = 0;
`endif
        if (!m_valid || rdy) begin
            if (c != 0) begin
                k = find_first(c, start);
                m_valid = 1;
                m_idx = 5'(k);
                c[k] = 1'b0;
                m_pend = c;
                m_ptr = (k + 1) % 32;
            end else begin
                m_valid = 0;
                m_pend = 0;
            end
        end else begin
            m_pend = c;
        end
    endtask

    task automatic chk_idx_seq(input string name, input logic [31:0] req, input int exp0);
        drive(1'b0, req, 1'b1);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_idx"}, 32'(out_idx), 32'(exp0));
    endtask

    initial begin
        tv[0]  = '{1, 32'hFFFF_FFFF, 1, 0, 0,  32'h0,         0, 0};
        tv[1]  = '{0, 32'h0,         1, 0, 0,  32'h0,         0, 0};
        tv[2]  = '{0, 32'h0,         1, 0, 0,  32'h0,         0, 0};
        tv[3]  = '{0, 32'h0,         1, 0, 0,  32'h0,         0, 0};
        tv[4]  = '{0, 32'h0,         1, 0, 0,  32'h0,         0, 0};
        tv[5]  = '{0, 32'h0,         1, 0, 0,  32'h0,         0, 0};
        tv[6]  = '{0, 32'h8000_0001, 1, 1, 0,  32'h8000_0000, 0, 1};
        tv[7]  = '{0, 32'h0,         1, 1, 31, 32'h0,         0, 1};
        tv[8]  = '{0, 32'h0,         1, 0, 31, 32'h0,         0, 0};
        tv[9]  = '{0, 32'h0000_0090, 0, 1, 4,  32'h80,        0, 1};
        tv[10] = '{0, 32'h0,         0, 1, 4,  32'h80,        0, 1};
        tv[11] = '{0, 32'h0,         0, 1, 4,  32'h80,        0, 1};
        tv[12] = '{0, 32'h0,         0, 1, 4,  32'h80,        0, 1};
        tv[13] = '{0, 32'h0,         1, 1, 7,  32'h0,         0, 1};
        tv[14] = '{0, 32'h0,         1, 0, 7,  32'h0,         0, 0};
        tv[15] = '{0, 32'h24,        0, 1, 2,  32'h20,        0, 1};
        tv[16] = '{0, 32'h20,        0, 1, 2,  32'h20,        1, 1};
        tv[17] = '{0, 32'h0,         0, 1, 2,  32'h20,        0, 1};
        tv[18] = '{0, 32'h4,         0, 1, 2,  32'h24,        0, 1};
        tv[19] = '{0, 32'h0,         1, 1, 2,  32'h20,        0, 1};
        tv[20] = '{0, 32'h0,         1, 1, 5,  32'h0,         0, 1};
        tv[21] = '{0, 32'h0,         1, 0, 5,  32'h0,         0, 0};
        tv[22] = '{0, 32'hF0F1_0000, 0, 1, 16, 32'hF0F0_0000, 0, 1};
        tv[23] = '{1, 32'hF000_0000, 0, 0, 0,  32'h0,         0, 0};
        tv[24] = '{0, 32'h0,         1, 0, 0,  32'h0,         0, 0};
        tv[25] = '{0, 32'h0000_000F, 1, 1, 0,  32'hE,         0, 1};
        tv[26] = '{0, 32'h0,         1, 1, 1,  32'hC,         0, 1};
        tv[27] = '{0, 32'h0,         1, 1, 2,  32'h8,         0, 1};
        tv[28] = '{0, 32'h0,         1, 1, 3,  32'h0,         0, 1};
        tv[29] = '{0, 32'h0,         1, 0, 3,  32'h0,         0, 0};

        for (int i = 0; i < 30; i++) begin
            drive(tv[i].rst, tv[i].req, tv[i].rdy);
            chk($sformatf("tv%0d_valid", i),  32'(out_valid), 32'(tv[i].v));
            chk($sformatf("tv%0d_idx", i),    32'(out_idx),   32'(tv[i].idx));
            chk($sformatf("tv%0d_pending", i), pending,       tv[i].pend);
            chk($sformatf("tv%0d_merged", i), 32'(merged),    32'(tv[i].m));
            chk($sformatf("tv%0d_busy", i),   32'(busy),      32'(tv[i].b));
        end

        // Held 0x3 with continuous ready: alternation only under round-robin.
        drive(1'b1, 32'h0, 1'b1);
`ifdef EVENT_ENCODER_RR_EN
        chk_idx_seq("hold3_c0", 32'h3, 0);
        chk_idx_seq("hold3_c1", 32'h3, 1);
        chk_idx_seq("hold3_c2", 32'h3, 0);
        chk_idx_seq("hold3_c3", 32'h3, 1);
`else
        chk_idx_seq("hold3_c0", 32'h3, 0);
        chk_idx_seq("hold3_c1", 32'h3, 0);
        chk_idx_seq("hold3_c2", 32'h3, 0);
        chk_idx_seq("hold3_c3", 32'h3, 0);
`endif

        // Wrap after serving index 31.
        drive(1'b1, 32'h0, 1'b1);
        chk_idx_seq("wrap_c0", 32'h8000_0006, 1);
        chk_idx_seq("wrap_c1", 32'h0, 2);
`ifdef EVENT_ENCODER_RR_EN
        chk_idx_seq("wrap_c2", 32'h1, 31);
        chk_idx_seq("wrap_c3", 32'h0, 0);
`else
        chk_idx_seq("wrap_c2", 32'h1, 0);
        chk_idx_seq("wrap_c3", 32'h0, 31);
`endif

        // Randomized run against the reference model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        r_rst;
            logic [31:0] r_req;
            logic        r_rdy;
            r_rst = (cyc == 0) || ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0:       r_req = 32'h0;
                1:       r_req = 32'(1) << $urandom_range(0, 31);
                2:       r_req = $urandom & $urandom & $urandom;
                default: r_req = $urandom & $urandom;
            endcase
            r_rdy = ($urandom_range(0, 3) != 0);
            model_step(r_rst, r_req, r_rdy);
            drive(r_rst, r_req, r_rdy);
            chk("rnd_valid",   32'(out_valid), 32'(m_valid));
            chk("rnd_idx",     32'(out_idx),   32'(m_idx));
            chk("rnd_pending", pending,        m_pend);
            chk("rnd_merged",  32'(merged),    32'(m_merged));
            chk("rnd_busy",    32'(busy),      32'(m_valid || (m_pend != 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
